// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and types for the register file with write scoreboard.
// X31 is the zero register: it reads as zero and is never tracked.
package regfile_scoreboard_pkg;

    localparam int DATA_W = 64;
    localparam int NREG   = 32;
    localparam int IDX_W  = 5;

    typedef logic [IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t XZR = 5'd31;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'b00,
        CNT_DEC  = 2'b01,
        CNT_INC  = 2'b10,
        CNT_BOTH = 2'b11
    } cnt_op_e;

    function automatic logic is_xzr(input reg_idx_t idx);
        return (idx == XZR);
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Issue, read and write-back signals of the scoreboarded register file.
// The pipeline drives through master; the register file sits on slave.
interface regfile_scoreboard_if
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W = regfile_scoreboard_pkg::DATA_W
);
    logic              issue_valid;
    logic              issue_wr;
    reg_idx_t          issue_rd;
    reg_idx_t          rd_addr1;
    reg_idx_t          rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              wb_en;
    reg_idx_t          wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              busy1;
    logic              busy2;
    logic              stall;
    logic              sb_err;

    modport master (
        output issue_valid, issue_wr, issue_rd, rd_addr1, rd_addr2,
        output wb_en, wb_addr, wb_data,
        input  rd_data1, rd_data2, busy1, busy2, stall, sb_err
    );

    modport slave (
        input  issue_valid, issue_wr, issue_rd, rd_addr1, rd_addr2,
        input  wb_en, wb_addr, wb_data,
        output rd_data1, rd_data2, busy1, busy2, stall, sb_err
    );

endinterface

// File: rtl/regfile_scoreboard_sb_counter.sv
// Two-bit saturating pending-write counter for one register.
// err flags an increment at 3 or a decrement at 0 in the current cycle.
module sb_counter
    import regfile_scoreboard_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] cnt,
    output logic       err
);
    logic [1:0] cnt_r;
    logic [1:0] cnt_nxt_s;
    logic       err_s;

    // Next count; simultaneous inc and dec cancel without error.
    always_comb begin
        cnt_nxt_s = cnt_r;
        err_s     = 1'b0;
        case (cnt_op_e'({inc, dec}))
            CNT_INC: begin
                if (cnt_r == 2'd3) begin
                    err_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + 2'd1;
                end
            end
            CNT_DEC: begin
                if (cnt_r == 2'd0) begin
                    err_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - 2'd1;
                end
            end
            CNT_HOLD: cnt_nxt_s = cnt_r;
            CNT_BOTH: cnt_nxt_s = cnt_r;
            default:  cnt_nxt_s = cnt_r;
        endcase
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= 2'd0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign cnt = cnt_r;
    assign err = err_s;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with same-cycle write-through bypass and per-register
// pending-write scoreboard that stalls ID while a source is outstanding.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W = regfile_scoreboard_pkg::DATA_W,
    parameter int NREG   = regfile_scoreboard_pkg::NREG
)(
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_scoreboard_if.slave  bus
);
    localparam int NCNT = NREG - 1;

    // Entry NREG-1 exists only so every 5-bit index is in range; it stays zero.
    logic [DATA_W-1:0] regs_r [NREG];
    logic [1:0]        cnt_s  [NREG];
    logic [NCNT-1:0]   inc_s;
    logic [NCNT-1:0]   dec_s;
    logic [NCNT-1:0]   err_s;
    logic              sb_err_r;
    logic              hit1_s;
    logic              hit2_s;
    logic              busy1_s;
    logic              busy2_s;
    logic              stall_s;
    logic              fire_s;
    logic [DATA_W-1:0] rd_data1_s;
    logic [DATA_W-1:0] rd_data2_s;

    function automatic logic [DATA_W-1:0] bypass_read(
        input reg_idx_t          addr,
        input logic              wen,
        input reg_idx_t          waddr,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] val;
        if (is_xzr(addr)) begin
            val = {DATA_W{1'b0}};
        end else if (wen && (waddr == addr)) begin
            val = wdata;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Read ports with write-through of the current write-back.
    always_comb begin
        rd_data1_s = bypass_read(bus.rd_addr1, bus.wb_en, bus.wb_addr, bus.wb_data,
                                 regs_r[bus.rd_addr1]);
        rd_data2_s = bypass_read(bus.rd_addr2, bus.wb_en, bus.wb_addr, bus.wb_data,
                                 regs_r[bus.rd_addr2]);
    end

    // A source is busy unless the write-back arriving now retires its last pending write.
    always_comb begin
        hit1_s  = bus.wb_en & (bus.wb_addr == bus.rd_addr1) & ~is_xzr(bus.wb_addr);
        hit2_s  = bus.wb_en & (bus.wb_addr == bus.rd_addr2) & ~is_xzr(bus.wb_addr);
        busy1_s = ~is_xzr(bus.rd_addr1) & ((cnt_s[bus.rd_addr1] - {1'b0, hit1_s}) != 2'd0);
        busy2_s = ~is_xzr(bus.rd_addr2) & ((cnt_s[bus.rd_addr2] - {1'b0, hit2_s}) != 2'd0);
        stall_s = bus.issue_valid & (busy1_s | busy2_s);
        fire_s  = bus.issue_valid & bus.issue_wr & ~stall_s & ~is_xzr(bus.issue_rd);
    end

    for (genvar r = 0; r < NCNT; r++) begin : g_cnt
        assign inc_s[r] = fire_s & (bus.issue_rd == reg_idx_t'(r));
        assign dec_s[r] = bus.wb_en & (bus.wb_addr == reg_idx_t'(r));

        sb_counter u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc_s[r]),
            .dec   (dec_s[r]),
            .cnt   (cnt_s[r]),
            .err   (err_s[r])
        );
    end

    assign cnt_s[NREG-1] = 2'b00;

    // Register array write and sticky scoreboard error; reset ignores issue/wb.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
            sb_err_r <= 1'b0;
        end else begin
            if (bus.wb_en && !is_xzr(bus.wb_addr)) begin
                regs_r[bus.wb_addr] <= bus.wb_data;
            end
            if (|err_s) begin
                sb_err_r <= 1'b1;
            end
        end
    end

    assign bus.rd_data1 = rd_data1_s;
    assign bus.rd_data2 = rd_data2_s;
    assign bus.busy1    = busy1_s;
    assign bus.busy2    = busy2_s;
    assign bus.stall    = stall_s;
    assign bus.sb_err   = sb_err_r;

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DATA_W, default 64, register data width.
REQ-002 Parameter NREG, default 32, register count; index NREG-1 (X31) is XZR.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 issue_valid  input  1  ID-stage instruction present.
REQ-006 issue_wr  input  1  issuing instruction writes a register.
REQ-007 issue_rd  input  5  issuing instruction destination (Rd).
REQ-008 rd_addr1  input  5  source Rn; rd_addr2  input  5  source Rm.
REQ-009 rd_data1, rd_data2  output  DATA_W  combinational read data for Rn, Rm.
REQ-010 wb_en  input  1  MEM/WB write enable; wb_addr  input  5  MEM/WB Rd; wb_data  input  DATA_W  write data.
REQ-011 busy1, busy2  output  1  Rn / Rm has an outstanding write not satisfied this cycle.
REQ-012 stall  output  1  hold ID stage this cycle.
REQ-013 sb_err  output  1  sticky scoreboard overflow/underflow flag.

Function
REQ-014 Write: on clk edge with wb_en=1 and wb_addr!=31, regs[wb_addr] <= wb_data; writes to X31 are discarded.
REQ-015 Read: rd_dataN = 0 when rd_addrN==31; else wb_data when wb_en=1 and wb_addr==rd_addrN (same-cycle write-through bypass); else regs[rd_addrN].
REQ-016 Scoreboard: one 2-bit pending counter per register 0..30; X31 has no counter and is never busy.
REQ-017 wb_hit_N = wb_en & (wb_addr==rd_addrN) & (wb_addr!=31).
REQ-018 busyN = (rd_addrN!=31) & ((cnt[rd_addrN] - wb_hit_N) != 0), subtraction unsigned, 2-bit.
REQ-019 stall = issue_valid & (busy1 | busy2); stall depends only on current-cycle inputs and state (no latency).
REQ-020 issue_fire = issue_valid & issue_wr & ~stall & (issue_rd!=31).
REQ-021 Counter update per register r: +1 if issue_fire & issue_rd==r; -1 if wb_en & wb_addr==r; both -> unchanged.
REQ-022 Overflow: increment with cnt==3 -> cnt stays 3, sb_err <= 1.
REQ-023 Underflow: decrement with cnt==0 -> cnt stays 0, sb_err <= 1; the register write of REQ-014 still occurs.
REQ-024 Simultaneous issue_fire and wb to same register with cnt==0 or 3: net unchanged, no error.
REQ-025 sb_err cleared only by reset.
REQ-026 No handshake back-pressure on wb port: wb always accepted.

Reset
REQ-027 While rst_n=0 at a clk edge: all regs <= 0, all counters <= 0, sb_err <= 0; issue and wb inputs ignored that edge.
REQ-028 Reset mid-operation discards all pending counts; first edge after rst_n=1 behaves as from empty.
REQ-029 Outputs after reset: rd_data1/2 = 0 (absent bypass), busy1/2=0, stall=0, sb_err=0.

Structure
REQ-030 Shared package holds DATA_W, NREG, XZR index (31) and the 5-bit register-index typedef.
REQ-031 One sub-module, sb_counter (2-bit saturating up/down counter with inc, dec, err outputs), instantiated 31 times; register array and bypass mux in top.

Verification
REQ-032 Reset then read X5, X31 -> rd_data 0, busy 0, stall 0.
REQ-033 wb_en=1, wb_addr=7, wb_data=0xDEAD, rd_addr1=7 same cycle -> rd_data1=0xDEAD that cycle; next cycle without wb -> 0xDEAD from array.
REQ-034 issue_fire rd=3; next cycle issue_valid with rd_addr2=3 -> busy2=1, stall=1; cycle wb_addr=3 arrives -> busy2=0, stall=0, rd_data2=wb_data.
REQ-035 Issue rd=4 three times, no wb -> cnt=3; fourth issue -> sb_err=1; wb_en to X4 with cnt 0 after reset -> sb_err=1.
REQ-036 wb_en=1 wb_addr=31 wb_data=0x1234 -> rd of X31 = 0 that and next cycle; issue rd=31 never sets busy.
REQ-037 Issue rd=9 then assert rst_n=0 one edge -> cnt[9]=0, busy on X9 = 0, sb_err=0.
